// File: rtl/credit_stream_unloader.sv
// Credit-gated FWFT receive buffer for a fixed-latency valid-tagged pipeline.
// Optional saturating dropped-sample counter enabled by defining CSU_DROP_COUNT_EN.
module credit_stream_unloader #(
    parameter int DATA_WIDTH   = 2,
    parameter int DEPTH        = 8,
    parameter int INFLIGHT_MAX = 15
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_issue,
    output logic                         issue_ok,
    input  logic [DATA_WIDTH-1:0]        datain,
    input  logic                         i_valid,
    output logic [DATA_WIDTH-1:0]        dataout,
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         err_overflow,
    output logic                         err_unexpected,
    output logic [15:0]                  drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int INF_W = $clog2(INFLIGHT_MAX + 1);
    localparam int SUM_W = ((LVL_W > INF_W) ? LVL_W : INF_W) + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      level_q, level_d;
    logic [INF_W-1:0]      inflight_q, inflight_d;
    logic                  err_ovf_q, err_ovf_d;
    logic                  err_unx_q, err_unx_d;

    logic                  full_s;
    logic                  rd_s;
    logic                  wr_s;
    logic                  drop_s;
    logic                  credit_s;
    logic [SUM_W-1:0]      committed_s;

    // Credits cover both buffered samples and samples still travelling in the pipeline.
    always_comb begin
        committed_s = SUM_W'(level_q) + SUM_W'(inflight_q);
        credit_s    = (committed_s < SUM_W'(DEPTH));
        full_s      = (level_q == LVL_W'(DEPTH));
        rd_s        = (level_q != {LVL_W{1'b0}}) && o_ready;
        wr_s        = i_valid && (!full_s || rd_s);
        drop_s      = i_valid && full_s && !rd_s;
    end

    // Next-state for pointers, occupancy, in-flight count and sticky flags.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        inflight_d = inflight_q;
        err_ovf_d  = err_ovf_q;
        err_unx_d  = err_unx_q;

        if (wr_s) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_s) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_s, rd_s})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase

        case ({i_issue, i_valid})
            2'b10: begin
                if (inflight_q != INF_W'(INFLIGHT_MAX)) begin
                    inflight_d = inflight_q + INF_W'(1);
                end else begin
                    inflight_d = inflight_q;
                end
            end
            2'b01: begin
                if (inflight_q != {INF_W{1'b0}}) begin
                    inflight_d = inflight_q - INF_W'(1);
                end else begin
                    inflight_d = inflight_q;
                end
            end
            default: inflight_d = inflight_q;
        endcase

        if ((i_issue && !credit_s) || drop_s) begin
            err_ovf_d = 1'b1;
        end else begin
            err_ovf_d = err_ovf_q;
        end

        if (i_valid && (inflight_q == {INF_W{1'b0}})) begin
            err_unx_d = 1'b1;
        end else begin
            err_unx_d = err_unx_q;
        end
    end

    // Control state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= {PTR_W{1'b0}};
            rd_ptr_q   <= {PTR_W{1'b0}};
            level_q    <= {LVL_W{1'b0}};
            inflight_q <= {INF_W{1'b0}};
            err_ovf_q  <= 1'b0;
            err_unx_q  <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            inflight_q <= inflight_d;
            err_ovf_q  <= err_ovf_d;
            err_unx_q  <= err_unx_d;
        end
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (rst_n && wr_s) begin
            mem_q[wr_ptr_q] <= datain;
        end
    end

`ifdef CSU_DROP_COUNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of arrivals lost to a full buffer.
    always_comb begin
        if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end else begin
            drop_cnt_d = drop_cnt_q;
        end
    end

    // Drop counter register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_cnt_q <= 16'h0000;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_count = drop_cnt_q;
`else
    assign drop_count = 16'h0000;
`endif

    assign issue_ok       = credit_s;
    assign dataout        = mem_q[rd_ptr_q];
    assign o_valid        = (level_q != {LVL_W{1'b0}});
    assign level          = level_q;
    assign err_overflow   = err_ovf_q;
    assign err_unexpected = err_unx_q;

endmodule

// File: tb/tb_credit_stream_unloader.sv
// Self-checking bench: directed scenarios plus randomized traffic against a queue-based model.
module tb_credit_stream_unloader;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int IMAX  = 15;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_issue;
    logic          issue_ok;
    logic [DW-1:0] datain;
    logic          i_valid;
    logic [DW-1:0] dataout;
    logic          o_valid;
    logic          o_ready;
    logic [3:0]    level;
    logic          err_overflow;
    logic          err_unexpected;
    logic [15:0]   drop_count;

    always #5 clk = ~clk;

    credit_stream_unloader #(
        .DATA_WIDTH  (DW),
        .DEPTH       (DEPTH),
        .INFLIGHT_MAX(IMAX)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_issue       (i_issue),
        .issue_ok      (issue_ok),
        .datain        (datain),
        .i_valid       (i_valid),
        .dataout       (dataout),
        .o_valid       (o_valid),
        .o_ready       (o_ready),
        .level         (level),
        .err_overflow  (err_overflow),
        .err_unexpected(err_unexpected),
        .drop_count    (drop_count)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] m_q[$];
    int            m_inflight = 0;
    bit            m_eov = 1'b0;
    bit            m_eun = 1'b0;
    int            m_drops = 0;
    logic [DW-1:0] rd_log[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    function automatic bit m_credit();
        return (m_q.size() + m_inflight) < DEPTH;
    endfunction

    function automatic int exp_drops();
`ifdef CSU_DROP_COUNT_EN
        return m_drops;
`else
        return 0;
`endif
    endfunction

    task automatic model_step(input bit rst, input bit iss, input bit vld,
                              input logic [DW-1:0] d, input bit rdy);
        bit rd;
        bit full;
        if (rst) begin
            m_q.delete();
            m_inflight = 0;
            m_eov      = 1'b0;
            m_eun      = 1'b0;
            m_drops    = 0;
        end else begin
            if (iss && !m_credit()) m_eov = 1'b1;
            if (vld && m_inflight == 0) m_eun = 1'b1;
            rd   = rdy && (m_q.size() > 0);
            full = (m_q.size() == DEPTH);
            if (rd) void'(m_q.pop_front());
            if (vld) begin
                if (!full || rd) begin
                    m_q.push_back(d);
                end else begin
                    m_eov = 1'b1;
                    if (m_drops < 65535) m_drops++;
                end
            end
            if (iss && !vld && m_inflight < IMAX) m_inflight++;
            else if (vld && !iss && m_inflight > 0) m_inflight--;
        end
    endtask

    task automatic check_all();
        check_val("level", 32'(level), 32'(m_q.size()));
        check_val("o_valid", 32'(o_valid), 32'(m_q.size() != 0));
        check_val("issue_ok", 32'(issue_ok), 32'(m_credit()));
        check_val("err_overflow", 32'(err_overflow), 32'(m_eov));
        check_val("err_unexpected", 32'(err_unexpected), 32'(m_eun));
        check_val("drop_count", 32'(drop_count), 32'(exp_drops()));
        if (m_q.size() > 0) check_val("dataout", 32'(dataout), 32'(m_q[0]));
    endtask

    task automatic cycle(input bit rst, input bit iss, input bit vld,
                         input logic [DW-1:0] d, input bit rdy);
        rst_n   = !rst;
        i_issue = iss;
        i_valid = vld;
        datain  = d;
        o_ready = rdy;
        if (!rst && o_valid === 1'b1 && rdy) rd_log.push_back(dataout);
        model_step(rst, iss, vld, d, rdy);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        bit      pipe[$];
        int      sent;
        bit      tog;
        bit      iss;
        bit      vld;
        bit      rdy;

        // Reset then idle
        cycle(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
        check_val("rst_o_valid", 32'(o_valid), 32'd0);
        check_val("rst_issue_ok", 32'(issue_ok), 32'd1);
        check_val("rst_level", 32'(level), 32'd0);
        check_val("rst_errs", 32'({err_overflow, err_unexpected}), 32'd0);
        check_val("rst_drops", 32'(drop_count), 32'd0);

        // Credit exhaustion
        for (int i = 0; i < 8; i++) begin
            check_val("credit_avail", 32'(issue_ok), 32'd1);
            cycle(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        end
        check_val("credit_exhausted", 32'(issue_ok), 32'd0);
        check_val("credit_no_err", 32'(err_overflow), 32'd0);
        cycle(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        check_val("credit_overissue_err", 32'(err_overflow), 32'd1);

        // Delayed arrivals and drain
        cycle(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, DW'(i), 1'b0);
        rd_log.delete();
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 8'd0, 1'b1);
        check_val("drain_count", 32'(rd_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            check_val("drain_order", 32'(rd_log[i]), 32'(i));
        check_val("drain_level", 32'(level), 32'd0);
        check_val("drain_issue_ok", 32'(issue_ok), 32'd1);
        check_val("drain_no_unexp", 32'(err_unexpected), 32'd0);

        // Full boundary with simultaneous read/write
        cycle(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, DW'(8'h10 + i), 1'b0);
        check_val("full_level", 32'(level), 32'd8);
        cycle(1'b0, 1'b0, 1'b1, 8'h55, 1'b1);
        check_val("full_rw_level", 32'(level), 32'd8);
        check_val("full_rw_no_drop", 32'(err_overflow), 32'd0);
        check_val("full_rw_head", 32'(dataout), 32'h11);
        cycle(1'b0, 1'b0, 1'b1, 8'h66, 1'b0);
        check_val("full_drop_err", 32'(err_overflow), 32'd1);
        check_val("full_drop_level", 32'(level), 32'd8);
`ifdef CSU_DROP_COUNT_EN
        check_val("full_drop_count", 32'(drop_count), 32'd1);
`else
        check_val("full_drop_count", 32'(drop_count), 32'd0);
`endif

        // Unexpected arrival
        cycle(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'd2, 1'b0);
        check_val("unexp_flag", 32'(err_unexpected), 32'd1);
        check_val("unexp_level", 32'(level), 32'd1);
        check_val("unexp_data", 32'(dataout), 32'd2);

        // Wrap with toggling ready
        cycle(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
        rd_log.delete();
        sent = 0;
        tog  = 1'b1;
        for (int c = 0; c < 200 && rd_log.size() < 20; c++) begin
            vld = (sent < 20) && (m_q.size() < DEPTH - 1);
            cycle(1'b0, vld, vld, DW'(sent), tog);
            if (vld) sent++;
            tog = !tog;
        end
        check_val("wrap_count", 32'(rd_log.size()), 32'd20);
        for (int i = 0; i < 20 && i < rd_log.size(); i++)
            check_val("wrap_order", 32'(rd_log[i]), 32'(i));

        // Mid-operation reset
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b1, DW'(8'h20 + i), 1'b0);
        check_val("mid_level_pre", 32'(level), 32'd3);
        cycle(1'b1, 1'b0, 1'b1, 8'h77, 1'b1);
        check_val("mid_level_post", 32'(level), 32'd0);
        check_val("mid_o_valid_post", 32'(o_valid), 32'd0);

        // Randomized traffic through a 4-cycle delay pipeline
        for (int i = 0; i < 4; i++) pipe.push_back(1'b0);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 399) == 0) begin
                cycle(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
                pipe.delete();
                for (int i = 0; i < 4; i++) pipe.push_back(1'b0);
            end else begin
                iss = m_credit() ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 29) == 0);
                vld = pipe.pop_front() || ($urandom_range(0, 39) == 0);
                pipe.push_back(iss);
                rdy = ($urandom_range(0, 2) != 0);
                cycle(1'b0, iss, vld, DW'($urandom), rdy);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
